// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types for the write-back stage
// Purpose: word/register types, the $ra index and the MEM/WB latch record.
// Ports: none (package).
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  localparam regbits_t REG_RA = 5'd31;

  // MEM/WB latch contents; the load-enable flag is consumed in MEM and not kept.
  typedef struct packed {
    logic  valid;
    logic  regwrite;
    logic  regdst;
    logic  jal;
    logic  memtoreg;
    logic  halt;
    word_t instr;
    word_t pc4;
    word_t alu;
    word_t ld;
  } wb_latch_t;

endpackage

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB latch, write-back select, halt tracking and retire count
// Purpose: captures the memory-stage result, holds load data across dhit/ihit skew,
//   forms wb_wen/wb_wsel/wb_wdat for the register file, tracks HALT, counts retirements.
// Ports:
//   CLK, RST (sync, active-high)        clock / reset
//   ihit, dhit, flush                   advance strobe, data hit, bubble request
//   mem_valid, mem_instr, mem_pc4,      MEM-stage instruction and results
//   mem_alu, dload
//   mem_regwrite, mem_regdst, mem_jal,  MEM-stage controls
//   mem_dren, mem_memtoreg, mem_halt
//   wb_valid, wb_wen, wb_wsel, wb_wdat, latched instruction and register-file write
//   wb_instr, wb_halt, retired
// Option: WB_BYPASS_EN adds prev_wen/prev_wsel/prev_wdat (last committed write).
module writeback_stage
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             flush,
  input  logic             mem_valid,
  input  word_t            mem_instr,
  input  word_t            mem_pc4,
  input  word_t            mem_alu,
  input  word_t            dload,
  input  logic             mem_regwrite,
  input  logic             mem_regdst,
  input  logic             mem_jal,
  input  logic             mem_dren,
  input  logic             mem_memtoreg,
  input  logic             mem_halt,
`ifdef WB_BYPASS_EN
  output logic             prev_wen,
  output regbits_t         prev_wsel,
  output word_t            prev_wdat,
`endif
  output logic             wb_valid,
  output logic             wb_wen,
  output regbits_t         wb_wsel,
  output word_t            wb_wdat,
  output word_t            wb_instr,
  output logic             wb_halt,
  output logic [CNT_W-1:0] retired
);

  wb_latch_t lat;
  word_t     hold_dat;
  logic      hold_ok;
  logic      adv;
  word_t     ld_dat;

  // A load may complete (dhit) before the fetch does (ihit); hold_ok lets the
  // stage advance later using the captured data.
  assign adv    = ihit & ~wb_halt & (~mem_dren | dhit | hold_ok);
  assign ld_dat = dhit ? dload : hold_dat;

  always_ff @(posedge CLK) begin
    if (RST) begin
      lat      <= '0;
      hold_dat <= '0;
      hold_ok  <= 1'b0;
      wb_halt  <= 1'b0;
      retired  <= '0;
`ifdef WB_BYPASS_EN
      prev_wen  <= 1'b0;
      prev_wsel <= '0;
      prev_wdat <= '0;
`endif
    end else begin
      if (adv) begin
        hold_ok  <= 1'b0;
        hold_dat <= '0;
        if (flush | ~mem_valid) begin
          lat <= '0;
        end else begin
          lat.valid    <= 1'b1;
          lat.regwrite <= mem_regwrite;
          lat.regdst   <= mem_regdst;
          lat.jal      <= mem_jal;
          lat.memtoreg <= mem_memtoreg;
          lat.halt     <= mem_halt;
          lat.instr    <= mem_instr;
          lat.pc4      <= mem_pc4;
          lat.alu      <= mem_alu;
          lat.ld       <= ld_dat;
          if (retired != {CNT_W{1'b1}})
            retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
`ifdef WB_BYPASS_EN
        prev_wen  <= wb_wen;
        prev_wsel <= wb_wsel;
        prev_wdat <= wb_wdat;
`endif
      end else if (dhit & mem_dren) begin
        hold_dat <= dload;
        hold_ok  <= 1'b1;
      end
      if (lat.valid & lat.halt)
        wb_halt <= 1'b1;
    end
  end

  always_comb begin
    wb_wsel = lat.instr[20:16];
    wb_wdat = lat.alu;
    if (lat.jal)
      wb_wsel = REG_RA;
    else if (lat.regdst)
      wb_wsel = lat.instr[15:11];
    if (lat.jal)
      wb_wdat = lat.pc4;
    else if (lat.memtoreg)
      wb_wdat = lat.ld;
  end

  assign wb_wen   = lat.valid & lat.regwrite & (wb_wsel != 5'd0) & ~wb_halt;
  assign wb_valid = lat.valid;
  assign wb_instr = lat.instr;

endmodule
